fetch_decode: RTL

FETCH_DECODE -- requirements
Module: fetch_decode

---
 rtl/fetch_decode_pkg.sv | 41 ++++
 rtl/fetch_decode_insn_decode.sv | 26 ++
 rtl/fetch_decode.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fetch_decode_pkg.sv
// Shared ISA definitions: opcode classes, opcode constants, decoded-field record
// and the fetch/decode FSM state encoding.
package fetch_decode_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } fd_state_e;

    // Opcode class is carried in opcode[4:3].
    typedef enum logic [1:0] {
        CLS_ALU    = 2'b00,
        CLS_MEM    = 2'b01,
        CLS_BRANCH = 2'b10,
        CLS_SYS    = 2'b11
    } op_class_e;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_LI   = 5'b00001;
    localparam logic [4:0] OP_SUB  = 5'b00010;
    localparam logic [4:0] OP_AND  = 5'b00100;
    localparam logic [4:0] OP_LD   = 5'b01000;
    localparam logic [4:0] OP_ST   = 5'b01001;
    localparam logic [4:0] OP_JMP  = 5'b10000;
    localparam logic [4:0] OP_HALT = 5'b11111;

    typedef struct packed {
        logic [4:0] opcode;
        logic [2:0] imm;
        logic [2:0] register;
        logic       is_alu_op;
        logic       is_mem_op;
        logic       mem_rw;
    } dec_fields_t;

    function automatic op_class_e op_class(input logic [4:0] opcode);
        return op_class_e'(opcode[4:3]);
    endfunction

endpackage

// File: rtl/fetch_decode_insn_decode.sv
// Purely combinational instruction decoder: one 8-bit instruction byte in,
// decoded fields out.
module insn_decode
    import fetch_decode_pkg::*;
(
    input  logic [7:0] i_instr,
    output logic [4:0] o_opcode,
    output logic [2:0] o_imm,
    output logic [2:0] o_register,
    output logic       o_is_alu_op,
    output logic       o_is_mem_op,
    output logic       o_mem_rw
);

    op_class_e w_class;

    assign w_class     = op_class(i_instr[7:3]);
    assign o_opcode    = i_instr[7:3];
    // imm and register share the same low three bits; the executor picks one.
    assign o_imm       = i_instr[2:0];
    assign o_register  = i_instr[2:0];
    assign o_is_alu_op = (w_class == CLS_ALU);
    assign o_is_mem_op = (w_class == CLS_MEM);
    assign o_mem_rw    = o_is_mem_op & i_instr[3];

endmodule

// File: rtl/fetch_decode.sv
// Instruction fetch/decode front end: fetches one byte per request, decodes it
// and holds the result for the executor, with PC redirect support.
module fetch_decode
    import fetch_decode_pkg::*;
#(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    output logic       mem_req,
    output logic [7:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] mem_rdata,
    input  logic       pc_load,
    input  logic [7:0] pc_target,
    output logic       dec_valid,
    input  logic       exe_ready,
    output logic [4:0] opcode,
    output logic [2:0] imm,
    output logic [2:0] register,
    output logic       is_alu_op,
    output logic       is_mem_op,
    output logic       mem_rw
);

    fd_state_e   r_state;
    fd_state_e   w_next_state;
    logic [7:0]  r_pc;
    logic [7:0]  r_target;
    logic        r_discard;
    dec_fields_t r_fields;
    dec_fields_t w_dec;

    insn_decode u_insn_decode (
        .i_instr     (mem_rdata),
        .o_opcode    (w_dec.opcode),
        .o_imm       (w_dec.imm),
        .o_register  (w_dec.register),
        .o_is_alu_op (w_dec.is_alu_op),
        .o_is_mem_op (w_dec.is_mem_op),
        .o_mem_rw    (w_dec.mem_rw)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: next state defaults to the current state before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (run) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // A redirect seen during this request makes the byte stale.
                if (mem_ack) begin
                    w_next_state = (pc_load || r_discard) ? ST_FETCH : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (exe_ready || pc_load) begin
                    w_next_state = run ? ST_FETCH : ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: only small control/field registers here, so all of them get an
    // asynchronous reset; decoded fields must read as zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc      <= RESET_PC;
            r_target  <= RESET_PC;
            r_discard <= 1'b0;
            r_fields  <= '0;
        end else begin
            case (r_state)
                ST_FETCH: begin
                    if (mem_ack) begin
                        r_discard <= 1'b0;
                        if (pc_load) begin
                            r_pc <= pc_target;
                        end else if (r_discard) begin
                            r_pc <= r_target;
                        end else begin
                            r_pc     <= r_pc + 8'd1;
                            r_fields <= w_dec;
                        end
                    end else if (pc_load) begin
                        // mem_addr must stay put until the ack; park the target.
                        r_discard <= 1'b1;
                        r_target  <= pc_target;
                    end
                end
                ST_IDLE, ST_HOLD: begin
                    if (pc_load) begin
                        r_pc <= pc_target;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (r_state == ST_FETCH);
    assign dec_valid = (r_state == ST_HOLD);
    assign mem_addr  = r_pc;
    assign opcode    = r_fields.opcode;
    assign imm       = r_fields.imm;
    assign register  = r_fields.register;
    assign is_alu_op = r_fields.is_alu_op;
    assign is_mem_op = r_fields.is_mem_op;
    assign mem_rw    = r_fields.mem_rw;

endmodule
